vending_machine_multi: RTL and testbench

Parametrised successor to the single-product vending controller: accepts 5/10/25 coins into a credit register, sells one of `N_ITEMS` products at per-item prices, and returns change coin-by-coin as 10- and 5-unit pulses. Sits between the coin-acceptor front end (one-cycle coin pulses) and the product/change actuators. Adds the following over the current block:
- multiple products
- stock-empty inhibit
- cancel/refund
- credit ceiling
- explicit coin rejection

---
 rtl/vm_pkg.sv | 42 ++++
 rtl/vm_change_unit.sv | 73 +++++++
 rtl/vending_machine_multi.sv | 205 ++++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared definitions for the multi-product vending controller.
//   vm_state_t   - controller state encoding
//   COINx_VAL    - coin denominations in credit units
//   price_of()   - extracts one price from the packed PRICES parameter vector
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } vm_state_t;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;
  localparam int COIN25_VAL = 25;

  // Widest packed price vector price_of() accepts, and the width of its result.
  localparam int PRICES_MAX_W = 1024;
  localparam int PRICE_FN_W   = 32;
  localparam int PRICE_POS_W  = $clog2(PRICES_MAX_W);

  // Price of item idx, where each price is w bits wide and item i sits at
  // bits [i*w +: w]. Result is zero-extended to PRICE_FN_W bits.
  function automatic logic [PRICE_FN_W-1:0] price_of(
    input logic [PRICES_MAX_W-1:0] prices,
    input int                      idx,
    input int                      w
  );
    logic [PRICE_FN_W-1:0]  p;
    logic [PRICE_POS_W-1:0] pos;
    p = '0;
    for (int b = 0; b < PRICE_FN_W; b++) begin
      if (b < w && (idx * w + b) < PRICES_MAX_W) begin
        pos  = PRICE_POS_W'(idx * w + b);
        p[b] = prices[pos];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/vm_change_unit.sv
// vm_change_unit: pays out a credit amount as a stream of 10- and 5-unit
// change pulses, one pulse per cycle, largest coin first.
//   clk, rst_n     - clock, asynchronous active-low reset
//   start_i        - load load_i and emit the first pulse on this edge
//   load_i         - amount to return (non-zero multiple of 5)
//   change_10_o    - registered 10-unit pulse
//   change_5_o     - registered 5-unit pulse
//   rem_next_o     - remaining amount after the pulse being issued this edge
//   done_o         - high in the cycle carrying the last pulse
module vm_change_unit
  import vm_pkg::*;
#(
  parameter int PRICE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [PRICE_W-1:0] load_i,
  output logic               change_10_o,
  output logic               change_5_o,
  output logic [PRICE_W-1:0] rem_next_o,
  output logic               done_o
);

  localparam logic [PRICE_W-1:0] TEN  = PRICE_W'(COIN10_VAL);
  localparam logic [PRICE_W-1:0] FIVE = PRICE_W'(COIN5_VAL);

  logic [PRICE_W-1:0] rem_q, rem_d;
  logic [PRICE_W-1:0] src;
  logic               active_q, active_d;
  logic               c10_q, c10_d;
  logic               c5_q, c5_d;
  logic               step10;

  // rem_q is the amount still owed after the pulse currently on the outputs,
  // so the pulse for the next cycle is derived from it directly.
  always_comb begin
    src      = start_i ? load_i : rem_q;
    step10   = (src >= TEN);
    rem_d    = rem_q;
    active_d = active_q;
    c10_d    = 1'b0;
    c5_d     = 1'b0;
    if (start_i || (active_q && rem_q != '0)) begin
      active_d = 1'b1;
      c10_d    = step10;
      c5_d     = ~step10;
      rem_d    = src - (step10 ? TEN : FIVE);
    end else if (active_q) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      active_q <= 1'b0;
      c10_q    <= 1'b0;
      c5_q     <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      active_q <= active_d;
      c10_q    <= c10_d;
      c5_q     <= c5_d;
    end
  end

  assign change_10_o = c10_q;
  assign change_5_o  = c5_q;
  assign rem_next_o  = rem_d;
  assign done_o      = active_q && (rem_q == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending controller.
// Accepts 5/10/25 coins up to MAX_CREDIT, vends one of N_ITEMS products at
// per-item prices, refuses out-of-stock or unaffordable selections, and
// returns change or a cancelled credit as 10/5-unit pulses.
//   clk, reset                 - clock, asynchronous active-low reset
//   coin_5/10/25               - one-cycle coin pulses
//   sel_valid, sel_idx         - product selection strobe and index
//   cancel                     - refund request
//   stock_empty                - per-item out-of-stock level
//   dispense, dispense_idx     - one-cycle vend pulse and item
//   sel_deny, coin_reject      - one-cycle refusal pulses
//   change_10, change_5        - change coin pulses
//   credit                     - current credit / change still owed
//   busy                       - high while vending or paying change
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                         N_ITEMS    = 4,
  parameter int                         PRICE_W    = 8,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                         MAX_CREDIT = 50,
  localparam int                        SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_5,
  input  logic               coin_10,
  input  logic               coin_25,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel_idx,
  input  logic               cancel,
  input  logic [N_ITEMS-1:0] stock_empty,
  output logic               dispense,
  output logic [SEL_W-1:0]   dispense_idx,
  output logic               sel_deny,
  output logic               coin_reject,
  output logic               change_10,
  output logic               change_5,
  output logic [PRICE_W-1:0] credit,
  output logic               busy
);

  localparam int SW = PRICE_W + 1;
  localparam logic [PRICES_MAX_W-1:0] PRICES_PAD = PRICES_MAX_W'(PRICES);

  vm_state_t          state_q, state_d;
  logic [PRICE_W-1:0] credit_q, credit_d;
  logic               dispense_q, dispense_d;
  logic [SEL_W-1:0]   dispense_idx_q, dispense_idx_d;
  logic               sel_deny_q, sel_deny_d;
  logic               coin_reject_q, coin_reject_d;
  logic               busy_q, busy_d;

  // Price lookup table, one entry per item.
  logic [PRICE_FN_W-1:0] price_tab [N_ITEMS];

  generate
    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_price
      assign price_tab[gi] = price_of(PRICES_PAD, gi, PRICE_W);
    end
  endgenerate

  // Selection qualification. An out-of-range index is redirected to item 0
  // only so the lookups stay in bounds; sel_in_range still refuses it.
  logic                  sel_in_range;
  logic [SEL_W-1:0]      sel_safe;
  logic [PRICE_FN_W-1:0] sel_price;
  logic                  sel_ok;

  assign sel_in_range = (32'(sel_idx) < 32'(N_ITEMS));
  assign sel_safe     = sel_in_range ? sel_idx : '0;
  assign sel_price    = price_tab[sel_safe];
  assign sel_ok       = sel_in_range && !stock_empty[sel_safe] &&
                        (PRICE_FN_W'(credit_q) >= sel_price);

  // Coin decode; the ceiling test is one bit wider than credit so it cannot wrap.
  logic [1:0]    n_coins;
  logic          coin_any;
  logic          coin_multi;
  logic [SW-1:0] coin_val;
  logic [SW-1:0] credit_sum;
  logic          coin_fits;

  assign n_coins    = {1'b0, coin_5} + {1'b0, coin_10} + {1'b0, coin_25};
  assign coin_any   = (n_coins != 2'd0);
  assign coin_multi = (n_coins > 2'd1);
  assign coin_val   = coin_25 ? SW'(COIN25_VAL) :
                      coin_10 ? SW'(COIN10_VAL) : SW'(COIN5_VAL);
  assign credit_sum = {1'b0, credit_q} + coin_val;
  assign coin_fits  = (credit_sum <= SW'(MAX_CREDIT));

  // Change unit is started on the edge that enters CHANGE, so its first
  // pulse appears in the first CHANGE cycle.
  logic               cu_start;
  logic [PRICE_W-1:0] cu_rem_next;
  logic               cu_done;
  logic               cu_c10;
  logic               cu_c5;

  assign cu_start = (credit_q != '0) &&
                    ((((state_q == IDLE) || (state_q == CREDIT)) && cancel) ||
                     (state_q == VEND));

  vm_change_unit #(
    .PRICE_W (PRICE_W)
  ) u_change (
    .clk         (clk),
    .rst_n       (reset),
    .start_i     (cu_start),
    .load_i      (credit_q),
    .change_10_o (cu_c10),
    .change_5_o  (cu_c5),
    .rem_next_o  (cu_rem_next),
    .done_o      (cu_done)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    dispense_d     = 1'b0;
    dispense_idx_d = '0;
    sel_deny_d     = 1'b0;
    coin_reject_d  = 1'b0;
    unique case (state_q)
      IDLE, CREDIT: begin
        if (cu_start) begin
          // Cancel with credit: refund everything, ignore select and coin.
          state_d       = CHANGE;
          credit_d      = cu_rem_next;
          coin_reject_d = coin_any;
        end else if (sel_valid && sel_ok) begin
          state_d        = VEND;
          dispense_d     = 1'b1;
          dispense_idx_d = sel_safe;
          credit_d       = credit_q - sel_price[PRICE_W-1:0];
          coin_reject_d  = coin_any;
        end else begin
          // A refused selection does not block a coin in the same cycle.
          sel_deny_d = sel_valid;
          if (coin_any) begin
            if (!coin_multi && coin_fits) begin
              credit_d = credit_sum[PRICE_W-1:0];
            end else begin
              coin_reject_d = 1'b1;
            end
          end
          state_d = (credit_d != '0) ? CREDIT : IDLE;
        end
      end
      VEND: begin
        coin_reject_d = coin_any;
        if (cu_start) begin
          state_d  = CHANGE;
          credit_d = cu_rem_next;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_any;
        if (cu_done) begin
          state_d  = IDLE;
          credit_d = '0;
        end else begin
          credit_d = cu_rem_next;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      dispense_q     <= 1'b0;
      dispense_idx_q <= '0;
      sel_deny_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      dispense_q     <= dispense_d;
      dispense_idx_q <= dispense_idx_d;
      sel_deny_q     <= sel_deny_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  assign dispense     = dispense_q;
  assign dispense_idx = dispense_idx_q;
  assign sel_deny     = sel_deny_q;
  assign coin_reject  = coin_reject_q;
  assign change_10    = cu_c10;
  assign change_5     = cu_c5;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed-vector bench for vending_machine_multi. Prices are set so that
// item 0 = 25, item 1 = 20, item 2 = 15, item 3 = 10; ceiling 50.
// Each vector drives one cycle of inputs and gives the outputs expected in
// the following cycle.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_5, coin_10, coin_25;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       cancel;
  logic [3:0] stock_empty;
  logic       dispense;
  logic [1:0] dispense_idx;
  logic       sel_deny, coin_reject, change_10, change_5;
  logic [7:0] credit;
  logic       busy;

  vending_machine_multi #(
    .N_ITEMS    (4),
    .PRICE_W    (8),
    .PRICES     ({8'd10, 8'd15, 8'd20, 8'd25}),
    .MAX_CREDIT (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_5       (coin_5),
    .coin_10      (coin_10),
    .coin_25      (coin_25),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .cancel       (cancel),
    .stock_empty  (stock_empty),
    .dispense     (dispense),
    .dispense_idx (dispense_idx),
    .sel_deny     (sel_deny),
    .coin_reject  (coin_reject),
    .change_10    (change_10),
    .change_5     (change_5),
    .credit       (credit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  coins;   // {coin_25, coin_10, coin_5}
    logic        sv;
    logic [1:0]  sidx;
    logic        can;
    logic [3:0]  stk;
    logic [15:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vq[$];

  // Expected output word: {dispense, idx, deny, reject, c10, c5, credit, busy}
  function automatic logic [15:0] pk(input int dp, input int di, input int dn, input int rj,
                                     input int c10, input int c5, input int cr, input int bz);
    return {1'(dp), 2'(di), 1'(dn), 1'(rj), 1'(c10), 1'(c5), 8'(cr), 1'(bz)};
  endfunction

  function automatic vec_t v(input int coins, input int sv, input int sidx, input int can,
                             input int stk, input logic [15:0] e);
    vec_t t;
    t.coins = 3'(coins);
    t.sv    = 1'(sv);
    t.sidx  = 2'(sidx);
    t.can   = 1'(can);
    t.stk   = 4'(stk);
    t.exp   = e;
    return t;
  endfunction

  function automatic string fmt(input logic [15:0] x);
    return $sformatf("dp=%0b idx=%0d deny=%0b rej=%0b c10=%0b c5=%0b credit=%0d busy=%0b",
                     x[15], x[14:13], x[12], x[11], x[10], x[9], x[8:1], x[0]);
  endfunction

  task automatic check(input string name, input logic [15:0] e);
    logic [15:0] got;
    got = {dispense, dispense_idx, sel_deny, coin_reject, change_10, change_5, credit, busy};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got %s, required %s", name, fmt(got), fmt(e));
    end else begin
      $display("ok   %s: %s", name, fmt(got));
    end
  endtask

  task automatic drive(input vec_t t);
    coin_25     = t.coins[2];
    coin_10     = t.coins[1];
    coin_5      = t.coins[0];
    sel_valid   = t.sv;
    sel_idx     = t.sidx;
    cancel      = t.can;
    stock_empty = t.stk;
  endtask

  task automatic step(input vec_t t, input string name);
    drive(t);
    @(posedge clk);
    #1;
    check(name, t.exp);
  endtask

  localparam int C5 = 1, C10 = 2, C25 = 4;

  initial begin
    reset = 1'b0;
    drive(v(0, 0, 0, 0, 0, '0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    // coins, sv, sidx, cancel, stock | dp, idx, deny, rej, c10, c5, credit, busy
    // 10 + 10, buy item 1 (20): exact price, no change
    vq.push_back(v(C10, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 10, 0)));
    vq.push_back(v(C10, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 20, 0)));
    vq.push_back(v(0,   1, 1, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));
    // 25, buy item 2 (15): one change_10
    vq.push_back(v(C25, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 25, 0)));
    vq.push_back(v(0,   1, 2, 0, 0, pk(1, 2, 0, 0, 0, 0, 10, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 0, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));
    // ceiling: 25 + 25 = 50, then 5 is rejected
    vq.push_back(v(C25, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 25, 0)));
    vq.push_back(v(C25, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 50, 0)));
    vq.push_back(v(C5,  0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, 50, 0)));
    // cancel refunds 50 as five change_10 pulses
    vq.push_back(v(0,   0, 0, 1, 0, pk(0, 0, 0, 0, 1, 0, 40, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 30, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 20, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 10, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 0, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));
    // cancel with zero credit does nothing; two coins at once rejected
    vq.push_back(v(0,   0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));
    vq.push_back(v(C5 + C10, 0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, 0, 0)));
    // credit 10, item 0 (25) unaffordable
    vq.push_back(v(C10, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 10, 0)));
    vq.push_back(v(0,   1, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 10, 0)));
    // credit 35, item 3 stocked out
    vq.push_back(v(C25, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 35, 0)));
    vq.push_back(v(0,   1, 3, 0, 8, pk(0, 0, 1, 0, 0, 0, 35, 0)));
    // cancel + select + coin: cancel wins, 35 = 10+10+10+5
    vq.push_back(v(C5,  1, 3, 1, 0, pk(0, 0, 0, 1, 1, 0, 25, 1)));
    vq.push_back(v(C25, 1, 0, 0, 0, pk(0, 0, 0, 1, 1, 0, 15, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 5, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));
    // accepted select rejects same-cycle coin; coin during VEND rejected
    vq.push_back(v(C25, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 25, 0)));
    vq.push_back(v(C5,  1, 3, 0, 0, pk(1, 3, 0, 1, 0, 0, 15, 1)));
    vq.push_back(v(C10, 0, 0, 0, 0, pk(0, 0, 0, 1, 1, 0, 5, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));
    // refused select still lets the coin in
    vq.push_back(v(C10, 1, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 10, 0)));
    vq.push_back(v(0,   0, 0, 1, 0, pk(0, 0, 0, 0, 1, 0, 0, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));
    // 30 + 25 overflows; buy item 0 from 30 leaves 5
    vq.push_back(v(C25, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 25, 0)));
    vq.push_back(v(C5,  0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 30, 0)));
    vq.push_back(v(C25, 0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, 30, 0)));
    vq.push_back(v(0,   1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 5, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 1)));
    vq.push_back(v(0,   0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)));

    foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));

    // Reset asserted mid-CHANGE: refund of 15 in progress.
    step(v(C10, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 10, 0)), "rst_seq_coin10");
    step(v(C5,  0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 15, 0)), "rst_seq_coin5");
    step(v(0,   0, 0, 1, 0, pk(0, 0, 0, 0, 1, 0, 5, 1)),  "rst_seq_cancel");
    drive(v(0, 0, 0, 0, 0, '0));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_clear", pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("held_in_reset", pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    step(v(0,  0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)), "post_reset_idle");
    step(v(C5, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 5, 0)), "post_reset_coin");
    step(v(0,  0, 0, 1, 0, pk(0, 0, 0, 0, 0, 1, 0, 1)), "post_reset_cancel");
    step(v(0,  0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)), "post_reset_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
